// File: rtl/instr_prefetch_unit_if.sv
// Handshake bundle between the instruction prefetch unit, the I-cache read port,
// the redirect source and the decode stage.
interface instr_prefetch_unit_if #(
  parameter int ADDR_SIZE = 32,
  parameter int INST_SIZE = 32,
  parameter int COUNT_W   = 3
);
  logic                 o_req;
  logic                 i_req_ready;
  logic [ADDR_SIZE-1:0] o_req_addr;
  logic                 i_resp_valid;
  logic [INST_SIZE-1:0] i_resp_instr;
  logic                 i_redirect_valid;
  logic [ADDR_SIZE-1:0] i_redirect_addr;
  logic                 o_instr_valid;
  logic                 i_instr_ready;
  logic [INST_SIZE-1:0] o_instruction;
  logic [ADDR_SIZE-1:0] o_pc;
  logic [ADDR_SIZE-1:0] o_pcplus4;
  logic [COUNT_W-1:0]   o_count;

  modport master (
    output o_req, o_req_addr, o_instr_valid, o_instruction, o_pc, o_pcplus4, o_count,
    input  i_req_ready, i_resp_valid, i_resp_instr, i_redirect_valid, i_redirect_addr,
           i_instr_ready
  );

  modport slave (
    input  o_req, o_req_addr, o_instr_valid, o_instruction, o_pc, o_pcplus4, o_count,
    output i_req_ready, i_resp_valid, i_resp_instr, i_redirect_valid, i_redirect_addr,
           i_instr_ready
  );
endinterface

// File: rtl/instr_prefetch_unit.sv
// In-order instruction prefetch front end: credit-limited cache reads, PC tag FIFO,
// registered instruction queue and redirect flush with stale-response discard.
module instr_prefetch_unit #(
  parameter int                   ADDR_SIZE       = 32,
  parameter logic [ADDR_SIZE-1:0] PC_BASE_ADDR    = {ADDR_SIZE{1'b0}},
  parameter int                   INST_SIZE       = 32,
  parameter int                   FIFO_DEPTH      = 4,
  parameter int                   MAX_OUTSTANDING = 2
) (
  input  logic                  i_aclk,
  input  logic                  i_areset_n,
  instr_prefetch_unit_if.master bus
);
  localparam int STEP  = INST_SIZE / 8;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int TAG_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int SUM_W = CNT_W + 1;
  localparam logic [ADDR_SIZE-1:0] STEP_A     = ADDR_SIZE'(STEP);
  localparam logic [ADDR_SIZE-1:0] ALIGN_MASK = ~ADDR_SIZE'(STEP - 1);

  function automatic logic [TAG_W-1:0] tag_inc(input logic [TAG_W-1:0] ptr);
    logic [TAG_W-1:0] nxt;
    if (ptr == TAG_W'(MAX_OUTSTANDING - 1)) begin
      nxt = {TAG_W{1'b0}};
    end else begin
      nxt = ptr + TAG_W'(1);
    end
    return nxt;
  endfunction

  logic [ADDR_SIZE-1:0] fetch_pc_r;
  logic [OUT_W-1:0]     outstanding_r;
  logic [OUT_W-1:0]     discard_r;
  logic [CNT_W-1:0]     count_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [INST_SIZE-1:0] q_instr_r [FIFO_DEPTH];
  logic [ADDR_SIZE-1:0] q_pc_r    [FIFO_DEPTH];
  logic [ADDR_SIZE-1:0] tag_pc_r  [MAX_OUTSTANDING];
  logic [TAG_W-1:0]     tag_rd_r;
  logic [TAG_W-1:0]     tag_wr_r;

  logic                 redirect_s;
  logic                 resp_s;
  logic                 req_s;
  logic                 req_fire_s;
  logic                 head_valid_s;
  logic                 instr_valid_s;
  logic                 push_s;
  logic                 pop_s;
  logic [SUM_W-1:0]     credit_sum_s;

  // Request credits and queue push/pop qualification.
  always_comb begin
    redirect_s    = bus.i_redirect_valid;
    resp_s        = bus.i_resp_valid;
    credit_sum_s  = SUM_W'(outstanding_r) + SUM_W'(count_r);
    head_valid_s  = (count_r != {CNT_W{1'b0}});
    req_s         = 1'b0;
    push_s        = 1'b0;
    // Every in-flight read holds a queue slot, so a response can never find the queue full.
    if (!redirect_s && (outstanding_r < OUT_W'(MAX_OUTSTANDING)) &&
        (credit_sum_s < SUM_W'(FIFO_DEPTH))) begin
      req_s = 1'b1;
    end else begin
      req_s = 1'b0;
    end
    req_fire_s    = req_s & bus.i_req_ready;
    instr_valid_s = head_valid_s & ~redirect_s;
    pop_s         = instr_valid_s & bus.i_instr_ready;
    if (resp_s && !redirect_s && (discard_r == {OUT_W{1'b0}})) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
  end

  // Fetch PC, in-flight read count and stale-response discard count.
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      fetch_pc_r    <= PC_BASE_ADDR;
      outstanding_r <= {OUT_W{1'b0}};
      discard_r     <= {OUT_W{1'b0}};
    end else begin
      if (redirect_s) begin
        fetch_pc_r <= bus.i_redirect_addr & ALIGN_MASK;
      end else if (req_fire_s) begin
        fetch_pc_r <= fetch_pc_r + STEP_A;
      end
      outstanding_r <= outstanding_r + OUT_W'(req_fire_s) - OUT_W'(resp_s);
      // Everything still in flight after a redirect belongs to the wrong path.
      if (redirect_s) begin
        discard_r <= outstanding_r - OUT_W'(resp_s);
      end else if (resp_s && (discard_r != {OUT_W{1'b0}})) begin
        discard_r <= discard_r - OUT_W'(1);
      end
    end
  end

  // Instruction queue storage, pointers and occupancy.
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        q_instr_r[i] <= {INST_SIZE{1'b0}};
        q_pc_r[i]    <= {ADDR_SIZE{1'b0}};
      end
    end else if (redirect_s) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        q_instr_r[wr_ptr_r] <= bus.i_resp_instr;
        q_pc_r[wr_ptr_r]    <= tag_pc_r[tag_rd_r];
        wr_ptr_r            <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  // PC tags of in-flight reads; popped by every response, stale or not.
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      tag_rd_r <= {TAG_W{1'b0}};
      tag_wr_r <= {TAG_W{1'b0}};
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        tag_pc_r[i] <= {ADDR_SIZE{1'b0}};
      end
    end else begin
      if (req_fire_s) begin
        tag_pc_r[tag_wr_r] <= fetch_pc_r;
        tag_wr_r           <= tag_inc(tag_wr_r);
      end
      if (resp_s) begin
        tag_rd_r <= tag_inc(tag_rd_r);
      end
    end
  end

  assign bus.o_req         = req_s;
  assign bus.o_req_addr    = fetch_pc_r;
  assign bus.o_instr_valid = instr_valid_s;
  assign bus.o_count       = count_r;
  assign bus.o_instruction = head_valid_s ? q_instr_r[rd_ptr_r] : {INST_SIZE{1'b0}};
  assign bus.o_pc          = head_valid_s ? q_pc_r[rd_ptr_r] : {ADDR_SIZE{1'b0}};
  assign bus.o_pcplus4     = head_valid_s ? (q_pc_r[rd_ptr_r] + STEP_A) : {ADDR_SIZE{1'b0}};

  instr_prefetch_unit_chk #(
    .FIFO_DEPTH      (FIFO_DEPTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (CNT_W),
    .OUT_W           (OUT_W)
  ) u_chk (
    .clk         (i_aclk),
    .rst_n       (i_areset_n),
    .push        (push_s),
    .resp        (resp_s),
    .count       (count_r),
    .outstanding (outstanding_r)
  );
endmodule

// Protocol and credit invariants of the prefetch unit.
module instr_prefetch_unit_chk #(
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = 3,
  parameter int OUT_W           = 2
) (
  input logic             clk,
  input logic             rst_n,
  input logic             push,
  input logic             resp,
  input logic [CNT_W-1:0] count,
  input logic [OUT_W-1:0] outstanding
);
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count == CNT_W'(FIFO_DEPTH))));
  a_outstanding_bound: assert property (@(posedge clk) disable iff (!rst_n)
    outstanding <= OUT_W'(MAX_OUTSTANDING));
  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst_n)
    !(resp && (outstanding == {OUT_W{1'b0}})));
endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Self-checking bench for instr_prefetch_unit: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.
module tb_instr_prefetch_unit;
  localparam int          ADDR_SIZE  = 32;
  localparam int          INST_SIZE  = 32;
  localparam int          FIFO_DEPTH = 4;
  localparam int          MAX_OUT    = 2;
  localparam int          CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] BASE       = 32'h0000_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_prefetch_unit_if #(.ADDR_SIZE(ADDR_SIZE), .INST_SIZE(INST_SIZE), .COUNT_W(CNT_W)) bus ();

  instr_prefetch_unit #(
    .ADDR_SIZE(ADDR_SIZE), .PC_BASE_ADDR(BASE), .INST_SIZE(INST_SIZE),
    .FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .i_aclk(clk), .i_areset_n(rst_n), .bus(bus)
  );

  typedef struct { logic [31:0] pc; bit stale; } fl_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } qe_t;
  typedef struct { logic [31:0] addr; int due; } cr_t;
  typedef struct {
    logic rr; logic rv; logic [31:0] ri; logic rd; logic [31:0] ra; logic ir;
    logic e_req; logic [31:0] e_addr; logic e_v; logic [31:0] e_pc; logic [31:0] e_pcp4;
    logic [31:0] e_instr; logic [31:0] e_cnt;
  } vec_t;

  fl_t         m_fl[$];
  qe_t         m_q[$];
  cr_t         cache_q[$];
  logic [31:0] m_pc;
  int          cyc = 0;
  int          last_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          checks = 0;
  int          errors = 0;
  vec_t        vecs[10];

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic vec_t mk(input logic rr, input logic rv, input logic [31:0] ri,
                              input logic rd, input logic [31:0] ra, input logic ir,
                              input logic er, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ep, input logic [31:0] epp,
                              input logic [31:0] ei, input logic [31:0] ec);
    vec_t v;
    v.rr = rr; v.rv = rv; v.ri = ri; v.rd = rd; v.ra = ra; v.ir = ir;
    v.e_req = er; v.e_addr = ea; v.e_v = ev; v.e_pc = ep; v.e_pcp4 = epp;
    v.e_instr = ei; v.e_cnt = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %08h expected %08h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s cyc=%0d: condition not reached within budget", name, cyc);
  endtask

  task automatic model_reset();
    m_fl.delete();
    m_q.delete();
    cache_q.delete();
    m_pc     = BASE;
    last_due = cyc;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic step(input bit redir, input logic [31:0] raddr, input bit iready, input bit rready);
    bit          resp;
    bit          e_req;
    bit          e_valid;
    logic [31:0] rinstr;
    logic [31:0] epc;
    fl_t         f;
    cr_t         c;
    int          d;
    resp   = 1'b0;
    rinstr = 32'h0;
    if (cache_q.size() != 0 && cache_q[0].due <= cyc) begin
      resp   = 1'b1;
      rinstr = dat(cache_q[0].addr);
    end
    bus.i_req_ready      = rready;
    bus.i_resp_valid     = resp;
    bus.i_resp_instr     = rinstr;
    bus.i_redirect_valid = redir;
    bus.i_redirect_addr  = raddr;
    bus.i_instr_ready    = iready;
    #1;
    e_req   = !redir && (m_fl.size() < MAX_OUT) && (m_fl.size() + m_q.size() < FIFO_DEPTH);
    e_valid = (m_q.size() != 0) && !redir;
    epc     = (m_q.size() != 0) ? m_q[0].pc : 32'h0;
    chk("req", 32'(bus.o_req), 32'(e_req));
    chk("req_addr", bus.o_req_addr, m_pc);
    chk("instr_valid", 32'(bus.o_instr_valid), 32'(e_valid));
    chk("count", 32'(bus.o_count), 32'(m_q.size()));
    chk("pc", bus.o_pc, epc);
    chk("pcplus4", bus.o_pcplus4, (m_q.size() != 0) ? epc + 32'd4 : 32'h0);
    if (m_q.size() != 0) chk("instruction", bus.o_instruction, m_q[0].instr);
    @(posedge clk);
    if (e_valid && iready) void'(m_q.pop_front());
    if (resp) begin
      c = cache_q.pop_front();
      if (m_fl.size() != 0) begin
        f = m_fl.pop_front();
        if (!f.stale && !redir) m_q.push_back('{rinstr, f.pc});
      end
    end
    if (e_req && rready) begin
      m_fl.push_back('{m_pc, 1'b0});
      d = cyc + int'($urandom_range(lat_max, lat_min));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      cache_q.push_back('{m_pc, d});
      m_pc = m_pc + 32'd4;
    end
    if (redir) begin
      m_q.delete();
      foreach (m_fl[i]) m_fl[i].stale = 1'b1;
      m_pc = raddr & 32'hFFFF_FFFC;
    end
    cyc++;
    @(negedge clk);
  endtask

  // Asserts reset mid-cycle, checks outputs follow immediately, then releases it.
  task automatic reset_dut();
    rst_n                = 1'b0;
    bus.i_req_ready      = 1'b0;
    bus.i_resp_valid     = 1'b0;
    bus.i_resp_instr     = 32'h0;
    bus.i_redirect_valid = 1'b0;
    bus.i_redirect_addr  = 32'h0;
    bus.i_instr_ready    = 1'b0;
    #1;
    chk("rst_req_addr", bus.o_req_addr, BASE);
    chk("rst_valid", 32'(bus.o_instr_valid), 32'h0);
    chk("rst_count", 32'(bus.o_count), 32'h0);
    chk("rst_pc", bus.o_pc, 32'h0);
    chk("rst_pcplus4", bus.o_pcplus4, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic run_until_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (m_q.size() != 0) begin
        ok = 1'b1;
        break;
      end
      step(1'b0, 32'h0, 1'b0, 1'b1);
    end
    if (m_q.size() != 0) ok = 1'b1;
  endtask

  initial begin
    bit ok;
    @(negedge clk);
    reset_dut();

    // Directed table: cache latency 1, redirect to a misaligned target, request back-off.
    vecs[0] = mk(1, 0, 32'h0,        0, 32'h0,   1, 1, 32'h000, 0, 32'h000, 32'h000, 32'h0,        0);
    vecs[1] = mk(1, 1, dat(32'h0),   0, 32'h0,   1, 1, 32'h004, 0, 32'h000, 32'h000, 32'h0,        0);
    vecs[2] = mk(1, 1, dat(32'h4),   0, 32'h0,   1, 1, 32'h008, 1, 32'h000, 32'h004, dat(32'h0),   1);
    vecs[3] = mk(1, 1, dat(32'h8),   0, 32'h0,   1, 1, 32'h00C, 1, 32'h004, 32'h008, dat(32'h4),   1);
    vecs[4] = mk(1, 1, dat(32'hC),   0, 32'h0,   1, 1, 32'h010, 1, 32'h008, 32'h00C, dat(32'h8),   1);
    vecs[5] = mk(1, 1, dat(32'h10),  1, 32'h202, 1, 0, 32'h014, 0, 32'h00C, 32'h010, dat(32'hC),   1);
    vecs[6] = mk(1, 0, 32'h0,        0, 32'h0,   1, 1, 32'h200, 0, 32'h000, 32'h000, 32'h0,        0);
    vecs[7] = mk(1, 1, dat(32'h200), 0, 32'h0,   1, 1, 32'h204, 0, 32'h000, 32'h000, 32'h0,        0);
    vecs[8] = mk(0, 0, 32'h0,        0, 32'h0,   1, 1, 32'h208, 1, 32'h200, 32'h204, dat(32'h200), 1);
    vecs[9] = mk(0, 0, 32'h0,        0, 32'h0,   1, 1, 32'h208, 0, 32'h000, 32'h000, 32'h0,        0);
    for (int i = 0; i < 10; i++) begin
      bus.i_req_ready      = vecs[i].rr;
      bus.i_resp_valid     = vecs[i].rv;
      bus.i_resp_instr     = vecs[i].ri;
      bus.i_redirect_valid = vecs[i].rd;
      bus.i_redirect_addr  = vecs[i].ra;
      bus.i_instr_ready    = vecs[i].ir;
      #1;
      chk("tbl_req", 32'(bus.o_req), 32'(vecs[i].e_req));
      chk("tbl_req_addr", bus.o_req_addr, vecs[i].e_addr);
      chk("tbl_valid", 32'(bus.o_instr_valid), 32'(vecs[i].e_v));
      chk("tbl_pc", bus.o_pc, vecs[i].e_pc);
      chk("tbl_pcplus4", bus.o_pcplus4, vecs[i].e_pcp4);
      chk("tbl_instr", bus.o_instruction, vecs[i].e_instr);
      chk("tbl_count", 32'(bus.o_count), vecs[i].e_cnt);
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end

    // Decode stall: requests stop when credits run out, nothing is lost.
    reset_dut();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("stall_count", 32'(bus.o_count), 32'd4);
    chk("stall_req", 32'(bus.o_req), 32'h0);
    chk("stall_head_pc", bus.o_pc, 32'h0);
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Redirect with two reads outstanding and a partly filled queue.
    reset_dut();
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && !(m_fl.size() == 2 && m_q.size() == 2); i++)
      step(1'b0, 32'h0, 1'b0, 1'b1);
    if (!(m_fl.size() == 2 && m_q.size() == 2)) fail_now("setup_redir100");
    step(1'b1, 32'h100, 1'b0, 1'b1);
    chk("redir_flush_count", 32'(bus.o_count), 32'h0);
    lat_min = 1; lat_max = 1;
    run_until_valid(20, ok);
    if (!ok) fail_now("redir100_deliver");
    chk("redir100_pc", bus.o_pc, 32'h100);
    chk("redir100_instr", bus.o_instruction, dat(32'h100));
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Redirect landing in the same cycle as a response.
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < 20 && !(cache_q.size() != 0 && cache_q[0].due <= cyc && m_fl.size() == 2); i++)
      step(1'b0, 32'h0, 1'b1, 1'b1);
    if (!(cache_q.size() != 0 && cache_q[0].due <= cyc)) fail_now("setup_redir_resp");
    step(1'b1, 32'h300, 1'b1, 1'b1);
    run_until_valid(20, ok);
    if (!ok) fail_now("redir300_deliver");
    chk("redir300_pc", bus.o_pc, 32'h300);

    // Misaligned target, back-to-back redirect, and PC wrap at the top of the space.
    step(1'b1, 32'h202, 1'b1, 1'b1);
    chk("align_addr", bus.o_req_addr, 32'h200);
    step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    run_until_valid(20, ok);
    if (!ok) fail_now("wrap_deliver");
    chk("wrap_pc", bus.o_pc, 32'hFFFF_FFFC);
    chk("wrap_pcplus4", bus.o_pcplus4, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    run_until_valid(20, ok);
    if (!ok) fail_now("wrap_next_deliver");
    chk("wrap_next_pc", bus.o_pc, 32'h0);

    // Reset asserted with two reads in flight, then fetch restarts from the base.
    for (int i = 0; i < 20 && m_fl.size() != 2; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    if (m_fl.size() != 2) fail_now("setup_midreset");
    reset_dut();
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Randomized traffic with varying cache latency.
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) begin
        lat_min = 1;
        lat_max = int'($urandom_range(4, 1));
      end
      step(($urandom_range(15, 0) == 0), $urandom(),
           ($urandom_range(3, 0) != 0), ($urandom_range(3, 0) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
